// File: rtl/vv_add_result_sink.sv
// vv_add_result_sink: receiving end of the vv_add output stream.
// Collects a programmed number of DATA_W elements over a vld/busy p2p
// channel into a local buffer indexed by arrival order, keeps a running
// modulo-2^DATA_W checksum, pulses done on completion, and offers a
// registered random-access read port for result readback.
//
// Ports:
//   clk       clock, rising edge
//   rst       synchronous active-low reset
//   start     one-cycle pulse, begins a collection (accepted in IDLE only)
//   vlen      element count, sampled on an accepted start
//   din_vld   producer has a valid element
//   din_busy  sink cannot accept; transfer when din_vld && !din_busy
//   din_data  element value
//   active    collection in progress
//   done      one-cycle completion pulse
//   count     elements accepted in current/last collection
//   checksum  modulo-2^DATA_W sum of accepted elements
//   rd_addr   readback address
//   rd_data   buffer[rd_addr], one-cycle latency, 0 when out of range
module vv_add_result_sink #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] vlen,
  input  logic              din_vld,
  output logic              din_busy,
  input  logic [DATA_W-1:0] din_data,
  output logic              active,
  output logic              done,
  output logic [ADDR_W-1:0] count,
  output logic [DATA_W-1:0] checksum,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  // One extra bit so DEPTH == 2**ADDR_W is representable as a length.
  localparam int unsigned      LEN_W   = ADDR_W + 1;
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FINISH  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   len_next;
  logic [ADDR_W-1:0]  count_next;
  logic [DATA_W-1:0]  checksum_next;
  logic [LEN_W-1:0]   vlen_cap;
  logic               xfer;
  logic               last;
  logic               in_range;

  logic [DATA_W-1:0]  mem [DEPTH];

  // Requested length clamped to the buffer size.
  assign vlen_cap = (LEN_W'(vlen) > DEPTH_L) ? DEPTH_L : LEN_W'(vlen);

  // din_busy is low only while in COLLECT, so this is the transfer strobe.
  assign xfer = (state == COLLECT) && din_vld && !din_busy;

  // Current transfer is the final one of the collection.
  assign last = ((LEN_W'(count) + LEN_W'(1)) == len);

  assign in_range = (LEN_W'(rd_addr) < DEPTH_L);

  // Next-state and datapath update.
  always_comb begin
    state_next    = state;
    len_next      = len;
    count_next    = count;
    checksum_next = checksum;
    case (state)
      IDLE: begin
        if (start) begin
          len_next      = vlen_cap;
          count_next    = '0;
          checksum_next = '0;
          state_next    = (vlen_cap == '0) ? FINISH : COLLECT;
        end
      end
      COLLECT: begin
        if (xfer) begin
          count_next    = count + ADDR_W'(1);
          checksum_next = checksum + din_data;
          if (last) begin
            state_next = FINISH;
          end
        end
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, datapath and status registers; status is decoded from the
  // next state so it lines up with the state it describes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      len      <= '0;
      count    <= '0;
      checksum <= '0;
      active   <= 1'b0;
      done     <= 1'b0;
      din_busy <= 1'b1;
    end else begin
      state    <= state_next;
      len      <= len_next;
      count    <= count_next;
      checksum <= checksum_next;
      active   <= (state_next == COLLECT);
      done     <= (state_next == FINISH);
      din_busy <= (state_next != COLLECT);
    end
  end

  // Result buffer write; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (rst && xfer) begin
      mem[count] <= din_data;
    end
  end

  // Registered read port; non-blocking update gives read-before-write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_data <= '0;
    end else if (in_range) begin
      rd_data <= mem[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: doc/vv_add_result_sink.md
Name: vv_add_result_sink

Overview:
- Receiving end of the vv_add output stream.
- Accepts 64-bit sum elements over a Stratus-style p2p channel (vld/busy), stores them by element index into a local result buffer, and keeps a running 64-bit checksum.
- Signals completion once the programmed vector length has been collected.
- The host or testbench reads results back through a registered random-access read port.

Parameters:
- DATA_W, 64, element width (matches vv_add adder output)
- ADDR_W, 10, index/counter width (matches vv_add 10-bit index)
- DEPTH, 1024, buffer entries; must be <= 2**ADDR_W

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous active-low reset
- start  input  1  one-cycle pulse; begins a collection
- vlen  input  ADDR_W  element count, sampled only on an accepted start
- din_vld  input  1  producer has valid element
- din_busy  output  1  sink cannot accept; transfer when din_vld && !din_busy
- din_data  input  DATA_W  element value
- active  output  1  collection in progress
- done  output  1  one-cycle pulse, collection complete
- count  output  ADDR_W  elements accepted in current/last collection
- checksum  output  DATA_W  modulo-2^DATA_W sum of accepted elements
- rd_addr  input  ADDR_W  readback address
- rd_data  output  DATA_W  buffer[rd_addr], registered

Behaviour:
- Reset (rst==0 at a clk edge) forces:
  - state IDLE; active=0, done=0, din_busy=1, count=0, checksum=0, rd_data=0.
  - Buffer contents are not cleared and are undefined after power-up.
- FSM states: IDLE, COLLECT, FINISH.
- IDLE:
  - din_busy=1.
  - On start=1: latch len = min(vlen, DEPTH); clear count and checksum.
  - If len==0, go to FINISH; otherwise go to COLLECT.
- COLLECT:
  - active=1, din_busy=0.
  - Each transfer cycle: buffer[count] <= din_data, checksum <= checksum + din_data (carry discarded), count <= count + 1.
  - When a transfer makes count+1 == len, go to FINISH in the same edge.
  - din_busy rises to 1 in the cycle after the last transfer, so no element beyond len is ever accepted.
  - din_vld=0 cycles: no change (bubbles allowed, any length).
  - start while in COLLECT or FINISH is ignored; vlen changes mid-collection have no effect.
- FINISH:
  - Held for exactly one cycle: done=1, active=0, din_busy=1. Then go to IDLE.
  - count and checksum hold their values until the next accepted start or reset.
- Latency:
  - First element may transfer in the cycle after the start edge.
  - done asserts the cycle after the final transfer edge.
- Count wrap: count never exceeds len <= DEPTH. With DEPTH=1024 and ADDR_W=10, len is capped at 1023 by vlen's width; no wrap occurs.
- Read port:
  - Always enabled, independent of FSM state.
  - rd_data <= buffer[rd_addr] on every edge (1-cycle latency).
  - Same-cycle write and read of one address returns the old data (read-before-write).
  - rd_addr >= DEPTH returns 0.
- Reset mid-collection: abort immediately to IDLE. No done pulse, count/checksum zeroed, partial buffer contents retained but unspecified.
- Simultaneous rst==0 and start: reset wins.

Test Plan:
- Reset, then start with vlen=4 and elements 1,2,3,0xFFFF_FFFF_FFFF_FFFF back-to-back -> din_busy low for exactly 4 transfers; done one cycle after 4th; count=4; checksum=5; rd_addr=3 gives 0xFFFF_FFFF_FFFF_FFFF one cycle later.
- vlen=3 with din_vld toggling 1,0,0,1,0,1 -> 3 transfers at vld-high cycles; done after 3rd; buffer[0..2] match in order.
- vlen=0 start -> done pulses on the 2nd edge after start; din_busy never drops; count=0; checksum=0.
- vlen=2; producer keeps din_vld=1 with a 3rd element after the 2nd transfer -> din_busy=1, 3rd element not accepted, buffer[2] unchanged, checksum reflects 2 elements only.
- Start during COLLECT with vlen=8, original vlen=2 -> ignored; done after 2 transfers; count=2.
- Assert rst=0 after 2 of 5 transfers -> active=0, din_busy=1, count=0, checksum=0, no done pulse. A new start with vlen=1 then completes normally with count=1.
